udp_echo_app_stats_log_writer: RTL
==================================

# udp_echo_app_stats_log_writer

Producer side of the UDP echo app statistics log. Counts received packets and bytes over fixed sampling intervals and writes one `udp_app_stats_struct` entry per interval into the stats log RAM. It maintains the circular write pointer (`curr_wr_addr`) and the sticky `has_wrapped` flag that the stats read path uses to answer metadata requests. It sits beside the echo app's RX path and drives the RAM write port.

## Interface

Parameters:
- INTERVAL_CYCLES, default 100000: sampling interval length in cycles; legal range is 2 or more.
- STATS_DEPTH_LOG2, package value: log depth is 2^STATS_DEPTH_LOG2 entries.

Ports (clock and reset first):
- clk  in  1  the single clock.
- rst  in  1  asynchronous, active-high reset.
- stats_en  in  1  logging enable.
- pkt_event_val  in  1  one received packet this cycle.
- pkt_event_bytes  in  16  payload bytes of that packet.
- log_wr_req_val  out  1  write request to log RAM.
- log_wr_req_rdy  in  1  RAM accepts the write.
- log_wr_req_addr  out  STATS_DEPTH_LOG2  write address.
- log_wr_req_data  out  udp_app_stats_struct  entry: timestamp[63:0], pkt_cnt[31:0], byte_cnt[31:0].
- curr_wr_addr  out  STATS_DEPTH_LOG2  next slot to be written.
- has_wrapped  out  1  sticky; the log has filled at least once.
- dropped_entries  out  16  saturating count of snapshots lost to backpressure.

## Operation

- Timestamp counter: 64-bit, free-running. It is 0 in the first cycle after reset deasserts and increments every cycle.
- Interval counter (`int_cnt`) advances only while `stats_en` is 1.
  - A snapshot cycle is any cycle with `stats_en` = 1 and `int_cnt` = INTERVAL_CYCLES-1.
  - `int_cnt` returns to 0 after a snapshot cycle.
- Accumulators:
  - On `pkt_event_val` while `stats_en` = 1: `pkt_cnt` += 1 and `byte_cnt` += `pkt_event_bytes`.
  - Both accumulators saturate at 2^32-1.
  - An event in a snapshot cycle is included in the interval that is ending.
- Snapshot:
  - The entry is {timestamp in the snapshot cycle, pkt_cnt, byte_cnt}, with both counts including that cycle's event.
  - The accumulators clear to 0 in the following cycle.
- `stats_en` = 0: `int_cnt` and the accumulators clear and stay at 0. A partial interval produces no entry. A pending write still completes.
- Write FSM:
  - WR_IDLE:
    - `log_wr_req_val` = 0.
    - A snapshot loads the hold register and moves the FSM to WR_PEND.
  - WR_PEND:
    - `log_wr_req_val` = 1, `log_wr_req_addr` = `curr_wr_addr`, `log_wr_req_data` = hold register.
    - On `val & rdy`: `curr_wr_addr` += 1, wrapping modulo 2^STATS_DEPTH_LOG2. If `curr_wr_addr` was 2^STATS_DEPTH_LOG2-1, `has_wrapped` <= 1.
    - Next state after a handshake: WR_IDLE, unless a snapshot occurs in the same cycle. In that case the hold register loads the new entry and the FSM stays in WR_PEND. Nothing is dropped.
    - A snapshot with no handshake in the same cycle drops the new entry and increments `dropped_entries`, saturating at 0xFFFF. The hold register keeps the older entry.
- `has_wrapped` clears only on reset.

## Timing

- Reset values: `log_wr_req_val` 0, `log_wr_req_addr` 0, `log_wr_req_data` 0, `curr_wr_addr` 0, `has_wrapped` 0, `dropped_entries` 0. Also FSM = WR_IDLE, timestamp 0, `int_cnt` 0, accumulators 0.
- Asserting `rst` mid-operation forces all of the above immediately (asynchronous), including dropping `log_wr_req_val` while a write is pending.
- Latency: `log_wr_req_val` rises in the cycle after the snapshot cycle.
- Addr/data stability: while `log_wr_req_val` = 1 and `log_wr_req_rdy` = 0, address and data do not change.
- `curr_wr_addr`, `has_wrapped` and `dropped_entries` update in the cycle after the triggering event.
- All outputs are registered. `log_wr_req_rdy` has no combinational path to any output.

## Test plan

1. First interval, INTERVAL_CYCLES=8, STATS_DEPTH_LOG2=2, `rdy` tied 1: reset, then `stats_en`=1 from timestamp 0; 100-byte events at timestamps 1, 3, 7 -> `val` in cycle 8 with addr 0, data {7, 3, 300}; `curr_wr_addr`=1 in cycle 9.
2. Wrap: 4 intervals with `rdy`=1 -> writes to addrs 0, 1, 2, 3; after the 4th accept, `curr_wr_addr`=0 and `has_wrapped`=1; 5th entry goes to addr 0 and `has_wrapped` stays 1.
3. Backpressure: `rdy`=0 from cycle 8 to cycle 20 -> first entry held stable; snapshot at timestamp 15 dropped, `dropped_entries`=1; accept when `rdy` rises; next entry written to addr 1 with timestamp 23.
4. Simultaneous accept and snapshot: hold `rdy`=0 until timestamp 15, raise it there -> entry{7} written to addr 0; entry{15} loaded in the same cycle; `val` stays 1; `dropped_entries` stays 0.
5. Enable gating: `stats_en` dropped at timestamp 4 after 2 events, re-raised at timestamp 10 -> no entry for the partial interval; the next snapshot comes 8 enabled cycles later with counts covering only post-10 events.
6. Async reset while WR_PEND -> `log_wr_req_val`, `curr_wr_addr`, `has_wrapped` and `dropped_entries` read 0 before the next clock edge.

Source files
------------

// File: rtl/udp_echo_app_stats_log_writer.sv
// UDP echo app statistics log producer: accumulates RX packet/byte counts per
// sampling interval and writes one stats entry per interval into the log RAM.
package udp_echo_app_stats_pkg;
  localparam int unsigned STATS_DEPTH_LOG2 = 10;

  typedef struct packed {
    logic [63:0] timestamp;
    logic [31:0] pkt_cnt;
    logic [31:0] byte_cnt;
  } udp_app_stats_struct;
endpackage

module udp_echo_app_stats_log_writer #(
  parameter int unsigned INTERVAL_CYCLES  = 100000,
  parameter int unsigned STATS_DEPTH_LOG2 = udp_echo_app_stats_pkg::STATS_DEPTH_LOG2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        stats_en,
  input  logic                                        pkt_event_val,
  input  logic [15:0]                                 pkt_event_bytes,
  output logic                                        log_wr_req_val,
  input  logic                                        log_wr_req_rdy,
  output logic [STATS_DEPTH_LOG2-1:0]                 log_wr_req_addr,
  output udp_echo_app_stats_pkg::udp_app_stats_struct log_wr_req_data,
  output logic [STATS_DEPTH_LOG2-1:0]                 curr_wr_addr,
  output logic                                        has_wrapped,
  output logic [15:0]                                 dropped_entries
);

  localparam int unsigned CNT_W = (INTERVAL_CYCLES > 1) ? $clog2(INTERVAL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INTERVAL_CYCLES - 1);

  typedef enum logic {WR_IDLE, WR_PEND} wr_state_e;

  wr_state_e state, state_next;

  logic [63:0]      timestamp;
  logic [CNT_W-1:0] int_cnt;
  logic [31:0]      pkt_cnt;
  logic [31:0]      byte_cnt;
  logic [31:0]      pkt_next;
  logic [31:0]      byte_next;
  logic [32:0]      byte_sum;
  logic             snapshot;
  logic             load_hold;
  logic             drop;
  logic             handshake;

  udp_echo_app_stats_pkg::udp_app_stats_struct entry;
  udp_echo_app_stats_pkg::udp_app_stats_struct hold;

  // Snapshot entry includes the event arriving in the snapshot cycle itself.
  always_comb begin
    snapshot = stats_en && (int_cnt == LAST_CNT);
    pkt_next = pkt_cnt;
    byte_sum = {1'b0, byte_cnt};
    if (stats_en && pkt_event_val) begin
      if (pkt_cnt != '1) pkt_next = pkt_cnt + 32'd1;
      byte_sum = {1'b0, byte_cnt} + 33'(pkt_event_bytes);
    end
    byte_next = byte_sum[32] ? '1 : byte_sum[31:0];
    entry.timestamp = timestamp;
    entry.pkt_cnt   = pkt_next;
    entry.byte_cnt  = byte_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timestamp <= '0;
      int_cnt   <= '0;
      pkt_cnt   <= '0;
      byte_cnt  <= '0;
    end else begin
      timestamp <= timestamp + 64'd1;
      if (!stats_en || snapshot) begin
        int_cnt  <= '0;
        pkt_cnt  <= '0;
        byte_cnt <= '0;
      end else begin
        int_cnt  <= int_cnt + CNT_W'(1);
        pkt_cnt  <= pkt_next;
        byte_cnt <= byte_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WR_IDLE;
    else     state <= state_next;
  end

  // A snapshot coinciding with a handshake reuses the freed hold register.
  always_comb begin
    state_next = state;
    load_hold  = 1'b0;
    drop       = 1'b0;
    handshake  = 1'b0;
    case (state)
      WR_IDLE: begin
        if (snapshot) begin
          load_hold  = 1'b1;
          state_next = WR_PEND;
        end
      end
      WR_PEND: begin
        handshake = log_wr_req_rdy;
        if (snapshot) begin
          if (log_wr_req_rdy) load_hold = 1'b1;
          else                drop      = 1'b1;
        end else if (log_wr_req_rdy) begin
          state_next = WR_IDLE;
        end
      end
      default: state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold            <= '0;
      curr_wr_addr    <= '0;
      has_wrapped     <= 1'b0;
      dropped_entries <= '0;
    end else begin
      if (load_hold) hold <= entry;
      if (handshake) begin
        curr_wr_addr <= curr_wr_addr + STATS_DEPTH_LOG2'(1);
        if (curr_wr_addr == '1) has_wrapped <= 1'b1;
      end
      if (drop && (dropped_entries != '1)) dropped_entries <= dropped_entries + 16'd1;
    end
  end

  assign log_wr_req_val  = (state == WR_PEND);
  assign log_wr_req_addr = curr_wr_addr;
  assign log_wr_req_data = hold;

endmodule
